// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller: button edge detect, 4-state FSM,
// count-tick prescaler and the display path with lap freeze.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] ones_in,
    input  logic [3:0] tens_in,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             ss_q, lr_q;
    logic             ss_e, lr_e;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic [3:0]       disp_ones_q, disp_ones_d;
    logic [3:0]       disp_tens_q, disp_tens_d;
    logic [3:0]       lap_ones_q, lap_ones_d;
    logic [3:0]       lap_tens_q, lap_tens_d;

    always_comb begin
        ss_e        = btn_ss & ~ss_q;
        lr_e        = btn_lr & ~lr_q;
        state_d     = state_q;
        cnt_clr_d   = 1'b0;
        lap_ones_d  = lap_ones_q;
        lap_tens_d  = lap_tens_q;

        // ss_e is checked first everywhere, so a simultaneous lr_e is dropped
        unique case (state_q)
            IDLE: begin
                if (ss_e) begin
                    state_d = RUN;
                end else if (lr_e) begin
                    cnt_clr_d = 1'b1;
                end
            end
            RUN: begin
                if (ss_e) begin
                    state_d = PAUSE;
                end else if (lr_e) begin
                    state_d    = LAP;
                    lap_ones_d = ones_in;
                    lap_tens_d = tens_in;
                end
            end
            LAP: begin
                if (ss_e) begin
                    state_d = PAUSE;
                end else if (lr_e) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (ss_e) begin
                    state_d = RUN;
                end else if (lr_e) begin
                    state_d   = IDLE;
                    cnt_clr_d = 1'b1;
                end
            end
        endcase

        // Prescaler follows the state being entered, so a pause freezes the
        // period exactly where it stood and a start counts from the press edge
        case (state_d)
            RUN, LAP: div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + CNT_W'(1);
            PAUSE:    div_cnt_d = div_cnt_q;
            default:  div_cnt_d = '0;
        endcase

        cnt_en_d = ((state_q == RUN) || (state_q == LAP)) && (div_cnt_q == DIV_MAX);

        if (state_q == LAP) begin
            disp_ones_d = lap_ones_q;
            disp_tens_d = lap_tens_q;
        end else begin
            disp_ones_d = ones_in;
            disp_tens_d = tens_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            ss_q        <= 1'b1;
            lr_q        <= 1'b1;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b0;
            disp_ones_q <= '0;
            disp_tens_q <= '0;
            lap_ones_q  <= '0;
            lap_tens_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            ss_q        <= btn_ss;
            lr_q        <= btn_lr;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_q   <= cnt_clr_d;
            disp_ones_q <= disp_ones_d;
            disp_tens_q <= disp_tens_d;
            lap_ones_q  <= lap_ones_d;
            lap_tens_q  <= lap_tens_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign disp_ones = disp_ones_q;
    assign disp_tens = disp_tens_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: scripted scenarios plus a random
// run against a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_ss  = 1'b0;
    logic       btn_lr  = 1'b0;
    logic [3:0] ones_in = '0;
    logic [3:0] tens_in = '0;
    logic       cnt_en, cnt_clr;
    logic [3:0] disp_ones, disp_tens;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_ss    (btn_ss),
        .btn_lr    (btn_lr),
        .ones_in   (ones_in),
        .tens_in   (tens_in),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .disp_ones (disp_ones),
        .disp_tens (disp_tens),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Reference model: a start/stop press toggles between running and not,
    // a lap/reset press freezes/unfreezes or clears; the prescaler is the
    // count of running cycles modulo TICK_DIV.
    int         m_mode, m_phase, nxt;
    logic       m_ss, m_lr, ss_p, lr_p, running;
    logic       e_en, e_clr;
    logic [3:0] e_do, e_dt, m_lo, m_lt;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode = M_IDLE; m_phase = 0; m_ss = 1'b1; m_lr = 1'b1;
                e_en = 1'b0; e_clr = 1'b0; e_do = '0; e_dt = '0; m_lo = '0; m_lt = '0;
            end else begin
                ss_p    = btn_ss && !m_ss;
                lr_p    = btn_lr && !m_lr && !ss_p;
                running = (m_mode == M_RUN) || (m_mode == M_LAP);
                e_en    = running && (m_phase == TICK_DIV - 1);
                e_clr   = lr_p && !running;
                e_do    = (m_mode == M_LAP) ? m_lo : ones_in;
                e_dt    = (m_mode == M_LAP) ? m_lt : tens_in;
                nxt     = m_mode;
                if (ss_p) begin
                    nxt = running ? M_PAUSE : M_RUN;
                end else if (lr_p) begin
                    if (m_mode == M_RUN) begin
                        nxt = M_LAP; m_lo = ones_in; m_lt = tens_in;
                    end else if (m_mode == M_LAP) begin
                        nxt = M_RUN;
                    end else begin
                        nxt = M_IDLE;
                    end
                end
                if (nxt == M_RUN || nxt == M_LAP) m_phase = (m_phase + 1) % TICK_DIV;
                else if (nxt == M_IDLE)           m_phase = 0;
                m_mode = nxt;
                m_ss   = btn_ss;
                m_lr   = btn_lr;
            end
        end
    end

    // Reset, then press start/stop; returns at the negedge one cycle after the
    // press edge, with state RUN, div_cnt=1 and both buttons low.
    task automatic go_run();
        reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk); btn_ss = 1'b1;
        @(negedge clk); btn_ss = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ones_in = 4'd9; tens_in = 4'd5;
        @(negedge clk); @(negedge clk);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b want 00", state); end
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", cnt_en); end
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL rst_clr: got %b want 0", cnt_clr); end
        checks++; if ({disp_tens, disp_ones} !== 8'h00) begin errors++; $display("FAIL rst_disp: got %h/%h want 0/0", disp_tens, disp_ones); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_idle: got %b want 00", state); end
        checks++; if ({disp_tens, disp_ones} !== 8'h59) begin errors++; $display("FAIL rst_passthru: got %h/%h want 5/9", disp_tens, disp_ones); end
    endtask

    task automatic test_run();
        go_run();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_state: got %b want 01", state); end
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (cnt_en !== ((k % 4) == 0)) begin
                errors++; $display("FAIL run_tick k=%0d: got %b want %b", k, cnt_en, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_pause_resume();
        go_run();
        repeat (4) @(negedge clk);
        btn_ss = 1'b1;
        @(negedge clk); btn_ss = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_state: got %b want 10", state); end
            checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL pause_en: got %b want 0", cnt_en); end
            @(negedge clk);
        end
        btn_ss = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); btn_ss = 1'b0;
            checks++;
            if (cnt_en !== (k == 3)) begin errors++; $display("FAIL resume_tick k=%0d: got %b want %b", k, cnt_en, k == 3); end
        end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL resume_state: got %b want 01", state); end
    endtask

    task automatic test_lap();
        int pulses;
        ones_in = 4'd3; tens_in = 4'd1;
        go_run();
        btn_lr = 1'b1;
        @(negedge clk);
        btn_lr = 1'b0; ones_in = 4'd7;
        pulses = 0;
        for (int k = 2; k <= 9; k++) begin
            if (k > 2) @(negedge clk);
            checks++; if (state !== 2'b11) begin errors++; $display("FAIL lap_state: got %b want 11", state); end
            checks++; if ({disp_tens, disp_ones} !== 8'h13) begin errors++; $display("FAIL lap_frozen: got %h/%h want 1/3", disp_tens, disp_ones); end
            if (cnt_en === 1'b1) pulses++;
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL lap_ticks: got %0d want 2", pulses); end
        btn_lr = 1'b1;
        @(negedge clk); btn_lr = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL unlap_state: got %b want 01", state); end
        @(negedge clk);
        checks++; if ({disp_tens, disp_ones} !== 8'h17) begin errors++; $display("FAIL unlap_disp: got %h/%h want 1/7", disp_tens, disp_ones); end
    endtask

    task automatic test_clear();
        go_run();
        @(negedge clk); btn_ss = 1'b1;
        @(negedge clk); btn_ss = 1'b0;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL clr_pause: got %b want 10", state); end
        btn_lr = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk); btn_lr = 1'b0;
            checks++; if (state !== 2'b00) begin errors++; $display("FAIL clr_state n=%0d: got %b want 00", n, state); end
            checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL clr_pulse n=%0d: got %b want 1", n, cnt_clr); end
            @(negedge clk);
            checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clr_width n=%0d: got %b want 0", n, cnt_clr); end
            btn_lr = (n == 0);
        end
        btn_ss = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); btn_ss = 1'b0;
            checks++; if (cnt_en !== (k == 4)) begin errors++; $display("FAIL clr_restart k=%0d: got %b want %b", k, cnt_en, k == 4); end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] prev;
        go_run();
        @(negedge clk);
        btn_ss = 1'b1; btn_lr = 1'b1;
        prev = 4'($urandom_range(0, 15)); ones_in = prev;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if (state !== 2'b10) begin errors++; $display("FAIL both_state k=%0d: got %b want 10", k, state); end
            checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL both_clr k=%0d: got %b want 0", k, cnt_clr); end
            checks++; if (disp_ones !== prev) begin errors++; $display("FAIL both_disp k=%0d: got %h want %h", k, disp_ones, prev); end
            prev = 4'($urandom_range(0, 15)); ones_in = prev;
        end
        btn_ss = 1'b0; btn_lr = 1'b0;
    endtask

    task automatic test_reset_mid();
        ones_in = 4'd5; tens_in = 4'd2;
        go_run();
        btn_lr = 1'b1;
        @(negedge clk); btn_lr = 1'b0;
        @(negedge clk);
        btn_ss = 1'b1; reset = 1'b1;
        #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL midrst_state: got %b want 00", state); end
        checks++; if ({cnt_en, cnt_clr} !== 2'b00) begin errors++; $display("FAIL midrst_pulses: got %b want 00", {cnt_en, cnt_clr}); end
        checks++; if ({disp_tens, disp_ones} !== 8'h00) begin errors++; $display("FAIL midrst_disp: got %h/%h want 0/0", disp_tens, disp_ones); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (state !== 2'b00) begin errors++; $display("FAIL midrst_hold k=%0d: got %b want 00", k, state); end
        end
        btn_ss = 1'b0;
    endtask

    task automatic test_random();
        reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++; if (state !== 2'(m_mode)) begin errors++; $display("FAIL rnd_state i=%0d: got %b want %b", i, state, 2'(m_mode)); end
            checks++; if (cnt_en !== e_en) begin errors++; $display("FAIL rnd_en i=%0d: got %b want %b", i, cnt_en, e_en); end
            checks++; if (cnt_clr !== e_clr) begin errors++; $display("FAIL rnd_clr i=%0d: got %b want %b", i, cnt_clr, e_clr); end
            checks++; if (disp_ones !== e_do) begin errors++; $display("FAIL rnd_ones i=%0d: got %h want %h", i, disp_ones, e_do); end
            checks++; if (disp_tens !== e_dt) begin errors++; $display("FAIL rnd_tens i=%0d: got %h want %h", i, disp_tens, e_dt); end
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 149) == 0) reset = 1'b1;
            if ($urandom_range(0, 4) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 4) == 0) btn_lr = ~btn_lr;
            ones_in = 4'($urandom_range(0, 15));
            tens_in = 4'($urandom_range(0, 15));
        end
        reset = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause_resume();
        test_lap();
        test_clear();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
